// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared constants and types for the carry-skip add sequencer
package csa_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

endpackage

// File: rtl/CSA.sv
// rtl/CSA.sv - 32-bit carry-skip adder built from 4-bit ripple blocks
module CSA
    import csa_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int BLK = 4;

    logic [DATA_W-1:0] p;
    logic              c;
    logic              r;

    assign p = a ^ b;

    // A block whose bits all propagate passes its incoming carry straight through.
    always_comb begin
        sum = '0;
        c   = cin;
        r   = 1'b0;
        for (int blk = 0; blk < DATA_W / BLK; blk++) begin
            r = c;
            for (int i = blk * BLK; i < (blk + 1) * BLK; i++) begin
                sum[i] = p[i] ^ r;
                r      = (a[i] & b[i]) | (p[i] & r);
            end
            c = (&p[blk*BLK +: BLK]) ? c : r;
        end
        cout = c;
    end

endmodule

// File: rtl/csa_add_sequencer.sv
// rtl/csa_add_sequencer.sv - registered operand/result stage around a multicycle adder
module csa_add_sequencer
    import csa_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic              carry_clr,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_zero
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] add_a_q, add_a_d;
    logic [DATA_W-1:0] add_b_q, add_b_d;
    logic              add_cin_q, add_cin_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] out_sum_q, out_sum_d;
    logic              out_cout_q, out_cout_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_zero_q, out_zero_d;
    logic              carry_eff;
    logic              is_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            carry_q    <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            carry_q    <= carry_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
            out_zero_q <= out_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_cin_d  = add_cin_q;
        carry_d    = carry_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;
        out_zero_d = out_zero_q;
        carry_eff  = carry_clr ? 1'b0 : carry_q;
        is_sub     = (in_op == OP_SUB) || (in_op == OP_SBC);

        case (state_q)
            ST_IDLE: begin
                // A clear coinciding with an ADC/SBC acceptance feeds the cleared flag.
                carry_d = carry_eff;
                if (in_valid) begin
                    add_a_d   = in_a;
                    add_b_d   = is_sub ? ~in_b : in_b;
                    add_cin_d = (in_op == OP_ADD) ? 1'b0 :
                                (in_op == OP_SUB) ? 1'b1 : carry_eff;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    out_sum_d  = add_sum;
                    out_cout_d = add_cout;
                    out_ovf_d  = (add_a_q[DATA_W-1] == add_b_q[DATA_W-1]) &&
                                 (add_sum[DATA_W-1] != add_a_q[DATA_W-1]);
                    out_zero_d = (add_sum == '0);
                    carry_d    = add_cout;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_csa_add_sequencer.sv
// tb/tb_csa_add_sequencer.sv - randomized self-checking bench for csa_add_sequencer with CSA
module tb_csa_add_sequencer;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [31:0] in_a      [NI];
    logic [31:0] in_b      [NI];
    logic [1:0]  in_op     [NI];
    logic        carry_clr [NI];
    logic [31:0] add_a     [NI];
    logic [31:0] add_b     [NI];
    logic        add_cin   [NI];
    logic [31:0] add_sum   [NI];
    logic        add_cout  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [31:0] out_sum   [NI];
    logic        out_cout  [NI];
    logic        out_ovf   [NI];
    logic        out_zero  [NI];

    int settle     [NI];
    bit ref_carry  [NI];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        csa_add_sequencer #(.SETTLE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_a      (in_a[g]),
            .in_b      (in_b[g]),
            .in_op     (in_op[g]),
            .carry_clr (carry_clr[g]),
            .add_a     (add_a[g]),
            .add_b     (add_b[g]),
            .add_cin   (add_cin[g]),
            .add_sum   (add_sum[g]),
            .add_cout  (add_cout[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_sum   (out_sum[g]),
            .out_cout  (out_cout[g]),
            .out_ovf   (out_ovf[g]),
            .out_zero  (out_zero[g])
        );
        CSA u_csa (
            .a    (add_a[g]),
            .b    (add_b[g]),
            .cin  (add_cin[g]),
            .sum  (add_sum[g]),
            .cout (add_cout[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: two's-complement add of a and (b or ~b) plus carry-in, in wide integers.
    task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic clr, input int hold);
        logic [31:0] bb;
        logic        cin;
        logic [32:0] s33;
        longint      ssum;
        logic        e_ovf;
        int          n;
        bb   = (op == 2'b01 || op == 2'b11) ? ~b : b;
        if (clr) ref_carry[k] = 1'b0;
        cin  = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : ref_carry[k];
        s33  = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        ssum = longint'($signed(a)) + longint'($signed(bb)) + longint'(cin);
        e_ovf = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);

        n = 0;
        while (!in_ready[k] && n < 50) begin tick(); n++; end
        n_cmp++;
        if (!in_ready[k]) begin n_bad++; $display("FAIL in_ready_timeout inst%0d: got %b want 1", k, in_ready[k]); end
        in_valid[k] = 1'b1; in_a[k] = a; in_b[k] = b; in_op[k] = op; carry_clr[k] = clr;
        tick();
        in_valid[k] = 1'b0; carry_clr[k] = 1'b0;

        n_cmp++;
        if ({add_a[k], add_b[k], add_cin[k]} !== {a, bb, cin}) begin
            n_bad++;
            $display("FAIL add_regs inst%0d op%0d: got %h/%h/%b want %h/%h/%b", k, op, add_a[k], add_b[k], add_cin[k], a, bb, cin);
        end

        n = 0;
        while (!out_valid[k] && n < 40) begin tick(); n++; end
        n_cmp++;
        if (n !== settle[k] || !out_valid[k]) begin
            n_bad++;
            $display("FAIL latency inst%0d: got %0d cycles (valid=%b) want %0d", k, n, out_valid[k], settle[k]);
        end
        n_cmp++;
        if (out_sum[k] !== s33[31:0]) begin n_bad++; $display("FAIL sum inst%0d op%0d a=%h b=%h: got %h want %h", k, op, a, b, out_sum[k], s33[31:0]); end
        n_cmp++;
        if (out_cout[k] !== s33[32]) begin n_bad++; $display("FAIL cout inst%0d op%0d a=%h b=%h: got %b want %b", k, op, a, b, out_cout[k], s33[32]); end
        n_cmp++;
        if (out_ovf[k] !== e_ovf) begin n_bad++; $display("FAIL ovf inst%0d op%0d a=%h b=%h: got %b want %b", k, op, a, b, out_ovf[k], e_ovf); end
        n_cmp++;
        if (out_zero[k] !== (s33[31:0] == 32'd0)) begin n_bad++; $display("FAIL zero inst%0d op%0d a=%h b=%h: got %b want %b", k, op, a, b, out_zero[k], s33[31:0] == 32'd0); end
        ref_carry[k] = s33[32];

        for (int i = 0; i < hold; i++) tick();
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        n_cmp++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL release inst%0d: got valid=%b ready=%b want 0/1", k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if ({add_a[k], add_b[k], add_cin[k], out_sum[k], out_cout[k], out_ovf[k], out_zero[k], out_valid[k]} !== '0) begin
                n_bad++;
                $display("FAIL reset_regs inst%0d: got a=%h b=%h sum=%h valid=%b want 0", k, add_a[k], add_b[k], out_sum[k], out_valid[k]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (in_ready[k] !== 1'b1) begin n_bad++; $display("FAIL reset_ready inst%0d: got %b want 1", k, in_ready[k]); end
        end
    endtask

    task automatic test_add();
        run_op(0, 2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        n_cmp++;
        if ({out_sum[0], out_cout[0], out_zero[0], out_ovf[0]} !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL add_const: got %h c%b z%b v%b want 0 c1 z1 v0", out_sum[0], out_cout[0], out_zero[0], out_ovf[0]);
        end
    endtask

    task automatic test_sub();
        run_op(0, 2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 1);
        n_cmp++;
        if ({out_sum[0], out_cout[0], out_ovf[0]} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_const: got %h c%b v%b want 7fffffff c1 v1", out_sum[0], out_cout[0], out_ovf[0]);
        end
    endtask

    task automatic test_chain();
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
        n_cmp++;
        if ({out_sum[0], out_cout[0]} !== {32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL chain_lo: got %h c%b want 0 c1", out_sum[0], out_cout[0]);
        end
        run_op(0, 2'b10, 32'h0, 32'h0, 1'b0, 0);
        n_cmp++;
        if ({out_sum[0], out_cout[0]} !== {32'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL chain_hi: got %h c%b want 1 c0", out_sum[0], out_cout[0]);
        end
        // Clear coinciding with ADC: carry-in must be the cleared value.
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
        run_op(0, 2'b10, 32'h5, 32'h6, 1'b1, 0);
        n_cmp++;
        if (out_sum[0] !== 32'd11) begin n_bad++; $display("FAIL clr_with_adc: got %h want 0000000b", out_sum[0]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] held_a;
        int n;
        in_valid[0] = 1'b1; in_a[0] = 32'h1234_0000; in_b[0] = 32'h0000_5678; in_op[0] = 2'b00;
        tick();
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 40) begin tick(); n++; end
        held = 32'h1234_5678;
        held_a = 32'h1234_0000;
        ref_carry[0] = 1'b0;
        in_valid[0] = 1'b1; in_a[0] = 32'hDEAD_BEEF; in_b[0] = 32'h1; in_op[0] = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (out_sum[0] !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || add_a[0] !== held_a) begin
                n_bad++;
                $display("FAIL backpressure cyc%0d: got sum=%h ready=%b valid=%b add_a=%h want %h/0/1/%h",
                         i, out_sum[0], in_ready[0], out_valid[0], add_a[0], held, held_a);
            end
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        n_cmp++;
        if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release: got ready=%b want 1", in_ready[0]); end
        run_op(0, 2'b01, 32'h10, 32'h3, 1'b0, 0);
    endtask

    task automatic test_reset_settle();
        in_valid[0] = 1'b1; in_a[0] = 32'hFFFF_FFFF; in_b[0] = 32'hFFFF_FFFF; in_op[0] = 2'b00;
        tick();
        in_valid[0] = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({add_a[0], add_b[0], add_cin[0], out_sum[0], out_cout[0], out_ovf[0], out_zero[0], out_valid[0]} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got a=%h b=%h cin=%b sum=%h valid=%b want 0", add_a[0], add_b[0], add_cin[0], out_sum[0], out_valid[0]);
        end
        for (int k = 0; k < NI; k++) ref_carry[k] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < settle[0] + 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL after_reset cyc%0d: got valid=%b ready=%b want 0/1", i, out_valid[0], in_ready[0]);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h0;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_sweep(input int k);
        for (int i = 0; i < 1000; i++) begin
            run_op(k, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end
    endtask

    initial begin
        settle[0] = 2; settle[1] = 1; settle[2] = 15;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; in_op[k] = '0;
            carry_clr[k] = 1'b0; out_ready[k] = 1'b0; ref_carry[k] = 1'b0;
        end
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_backpressure();
        test_reset_settle();
        test_sweep(1);
        test_sweep(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
